// File: rtl/mem_interface_unit.sv
// Memory interface unit: program counter, data address register, instruction
// register, memory-mapped LED output and switch input, fetch counter and a
// sticky bus-error flag for accesses to unmapped I/O addresses.
module mem_interface_unit #(
  parameter logic [8:0] LED_ADDR = 9'h100,
  parameter logic [8:0] SW_ADDR  = 9'h140
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  mem_cmd,
  input  logic        load_pc,
  input  logic        reset_pc,
  input  logic        load_addr,
  input  logic        addr_sel,
  input  logic        load_ir,
  input  logic [15:0] datapath_out,
  input  logic [15:0] ram_rdata,
  input  logic [7:0]  sw,
  output logic [8:0]  mem_addr,
  output logic        ram_we,
  output logic [15:0] ram_wdata,
  output logic [15:0] read_data,
  output logic [15:0] ir,
  output logic [8:0]  pc,
  output logic [7:0]  led,
  output logic [15:0] fetch_count,
  output logic        bus_err
);

  localparam logic [1:0] CMD_READ  = 2'b01;
  localparam logic [1:0] CMD_WRITE = 2'b10;

  logic [8:0]  pc_q, pc_d;
  logic [8:0]  dar_q, dar_d;
  logic [15:0] ir_q, ir_d;
  logic [7:0]  led_q, led_d;
  logic [15:0] fetch_count_q, fetch_count_d;
  logic        bus_err_q, bus_err_d;
  logic [7:0]  sw_meta_q, sw_sync_q;

  logic rd_cmd, wr_cmd, in_ram, at_led, at_sw;

  // Address selection and access decode (all combinational).
  always_comb begin
    mem_addr  = addr_sel ? pc_q : dar_q;
    rd_cmd    = (mem_cmd == CMD_READ);
    wr_cmd    = (mem_cmd == CMD_WRITE);
    in_ram    = ~mem_addr[8];
    at_led    = (mem_addr == LED_ADDR);
    at_sw     = (mem_addr == SW_ADDR);
    ram_we    = wr_cmd & in_ram;
    ram_wdata = datapath_out;
    read_data = 16'h0000;
    if (rd_cmd) begin
      if (in_ram)      read_data = ram_rdata;
      else if (at_sw)  read_data = {8'h00, sw_sync_q};
      else if (at_led) read_data = {8'h00, led_q};
    end
  end

  // Next-state computation for every architectural register.
  always_comb begin
    pc_d          = pc_q;
    dar_d         = dar_q;
    ir_d          = ir_q;
    led_d         = led_q;
    fetch_count_d = fetch_count_q;
    bus_err_d     = bus_err_q;
    if (load_pc)   pc_d  = reset_pc ? 9'h000 : pc_q + 9'd1;
    if (load_addr) dar_d = datapath_out[8:0];
    if (load_ir) begin
      ir_d = read_data;
      if (fetch_count_q != 16'hFFFF) fetch_count_d = fetch_count_q + 16'd1;
    end
    if (wr_cmd && at_led) led_d = datapath_out[7:0];
    // Unmapped I/O: reads may only hit SW/LED, writes may only hit LED.
    if (rd_cmd && !in_ram && !at_sw && !at_led) bus_err_d = 1'b1;
    if (wr_cmd && !in_ram && !at_led)           bus_err_d = 1'b1;
  end

  // State registers, including the two-flop switch synchronizer.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q          <= 9'h000;
      dar_q         <= 9'h000;
      ir_q          <= 16'h0000;
      led_q         <= 8'h00;
      fetch_count_q <= 16'h0000;
      bus_err_q     <= 1'b0;
      sw_meta_q     <= 8'h00;
      sw_sync_q     <= 8'h00;
    end else begin
      pc_q          <= pc_d;
      dar_q         <= dar_d;
      ir_q          <= ir_d;
      led_q         <= led_d;
      fetch_count_q <= fetch_count_d;
      bus_err_q     <= bus_err_d;
      sw_meta_q     <= sw;
      sw_sync_q     <= sw_meta_q;
    end
  end

  assign ir          = ir_q;
  assign pc          = pc_q;
  assign led         = led_q;
  assign fetch_count = fetch_count_q;
  assign bus_err     = bus_err_q;

endmodule

// File: doc/mem_interface_unit.md
MEM_INTERFACE_UNIT -- requirements
Module: mem_interface_unit

Interface
REQ-001 SHALL have parameter LED_ADDR, default 9'h100, memory-mapped LED register address.
REQ-002 SHALL have parameter SW_ADDR, default 9'h140, memory-mapped switch input address.
REQ-003 SHALL use one clock and an asynchronous, active-high reset, with ports named clk and reset.
REQ-004 clk  in  1  rising-edge clock for all state.
REQ-005 reset  in  1  asynchronous, active-high reset.
REQ-006 mem_cmd  in  2  memory command: 00 none, 01 read, 10 write, 11 treated as none.
REQ-007 load_pc, reset_pc, load_addr, addr_sel, load_ir  in  1 each  controller strobes.
REQ-008 datapath_out  in  16  datapath result, used as address source and write data.
REQ-009 ram_rdata  in  16  read data from synchronous RAM, valid one cycle after address presented.
REQ-010 sw  in  8  asynchronous board switches.
REQ-011 mem_addr  out  9  RAM/IO address.
REQ-012 ram_we  out  1  RAM write enable.
REQ-013 ram_wdata  out  16  RAM write data.
REQ-014 read_data  out  16  muxed read data returned to datapath and IR.
REQ-015 ir  out  16  instruction register.
REQ-016 pc  out  9  program counter.
REQ-017 led  out  8  LED register.
REQ-018 fetch_count  out  16  instruction-fetch counter.
REQ-019 bus_err  out  1  sticky unmapped-access flag.

Function
REQ-020 On posedge clk with load_pc=1, pc SHALL load 9'h000 if reset_pc=1, else pc+1 mod 512 (9'h1FF wraps to 9'h000).
REQ-021 With load_pc=0, pc SHALL hold regardless of reset_pc.
REQ-022 On posedge clk with load_addr=1, the data address register (dar) SHALL load datapath_out[8:0]; otherwise it holds.
REQ-023 mem_addr SHALL be combinational: pc when addr_sel=1, dar when addr_sel=0.
REQ-024 ram_wdata SHALL equal datapath_out combinationally.
REQ-025 ram_we SHALL be 1 only when mem_cmd=10 and mem_addr[8]=0.
REQ-026 read_data SHALL be combinational when mem_cmd=01:
- ram_rdata if mem_addr[8]=0
- {8'h00, sw_sync} if mem_addr=SW_ADDR
- {8'h00, led} if mem_addr=LED_ADDR
- 16'h0000 otherwise, and also whenever mem_cmd is not 01.
REQ-027 sw SHALL pass through a 2-flop synchronizer (sw_sync); a sw change SHALL be visible on read_data on the 2nd posedge after it occurs, not earlier.
REQ-028 led SHALL load datapath_out[7:0] on posedge clk when mem_cmd=10 and mem_addr=LED_ADDR; otherwise it holds.
REQ-029 ir SHALL load read_data on posedge clk when load_ir=1; otherwise it holds.
REQ-030 fetch_count SHALL increment by 1 on each posedge with load_ir=1 and saturate at 16'hFFFF.
REQ-031 bus_err SHALL set on posedge clk on any of the following, and stay set until reset:
- mem_cmd=01 with mem_addr[8]=1 other than SW_ADDR or LED_ADDR
- mem_cmd=10 with mem_addr[8]=1 other than LED_ADDR.
REQ-032 A write to SW_ADDR SHALL set bus_err, SHALL NOT assert ram_we, and SHALL NOT change led.
REQ-033 Simultaneous load_pc, load_addr and load_ir in one cycle SHALL each take effect independently; ir SHALL capture read_data based on the pre-edge mem_addr.
REQ-034 Unmapped accesses SHALL NOT alter pc, dar, ir or led beyond the rules above.

Reset
REQ-035 While reset=1, regardless of clk, the following SHALL clear: pc=0, dar=0, ir=16'h0000, led=8'h00, fetch_count=0, bus_err=0, and both synchronizer stages=0.
REQ-036 Combinational outputs SHALL follow the cleared state during reset: mem_addr=0 when addr_sel=0, and ram_we follows mem_cmd.
REQ-037 Reset asserted mid-operation (for example, between a read command and load_ir) SHALL discard the pending load; the first load_ir after release SHALL count as fetch 1.

Verification
REQ-038 Reset, then 3 cycles of load_pc=1, reset_pc=0 -> pc=3; one cycle of load_pc=1, reset_pc=1 -> pc=0; pc=9'h1FF plus load_pc -> pc=0.
REQ-039 dar=9'h005 via load_addr with datapath_out=16'h0005, addr_sel=0, mem_cmd=10, datapath_out=16'hABCD -> ram_we=1, mem_addr=5, ram_wdata=16'hABCD.
REQ-040 Write datapath_out=16'h0055 to LED_ADDR -> led=8'h55, ram_we=0, bus_err=0; then read LED_ADDR -> read_data=16'h0055.
REQ-041 sw=8'hA5, read SW_ADDR each cycle -> read_data=16'h0000 for the first cycle, 16'h00A5 from the 2nd post-change edge onward.
REQ-042 Write to 9'h1C0 -> bus_err=1 and remains 1 for 10 idle cycles; reset -> bus_err=0.
REQ-043 fetch_count preloaded to 16'hFFFE by 65534 load_ir pulses, then 2 more load_ir pulses -> 16'hFFFF, held at 16'hFFFF.
